// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: drives the handshaked data-memory bus, stalls upstream
// while an access is outstanding, and holds the MEM/WB pipeline register.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] mem_Alu_Result,
  input  logic [31:0] mem_rb,
  input  logic        mem_wmem,
  input  logic        mem_m2reg,
  input  logic        mem_wreg,
  input  logic [4:0]  mem_rn,
  output logic        mem_stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic [31:0] wb_Alu_Result,
  output logic [31:0] wb_mdata,
  output logic        wb_m2reg,
  output logic        wb_wreg,
  output logic [4:0]  wb_rn,
  output logic        bus_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic memop;
  logic is_load;
  logic wait_last;

  logic        dm_req_nxt;
  logic        dm_we_nxt;
  logic [31:0] dm_addr_nxt;
  logic [31:0] dm_wdata_nxt;
  logic [31:0] wb_alu_nxt;
  logic [31:0] wb_mdata_nxt;
  logic        wb_m2reg_nxt;
  logic        wb_wreg_nxt;
  logic [4:0]  wb_rn_nxt;
  logic        bus_err_nxt;

  // A store wins when both wmem and m2reg are set.
  assign memop     = mem_wmem | mem_m2reg;
  assign is_load   = mem_m2reg & ~mem_wmem;
  assign wait_last = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (memop) begin
          state_nxt = BUSY;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (dm_ready || wait_last) state_nxt = IDLE;
        else                       cnt_nxt   = cnt + CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Default WB load is a bubble; the bus fields hold unless a new access issues.
  always_comb begin
    mem_stall    = 1'b0;
    dm_req_nxt   = dm_req;
    dm_we_nxt    = dm_we;
    dm_addr_nxt  = dm_addr;
    dm_wdata_nxt = dm_wdata;
    bus_err_nxt  = bus_err;
    wb_alu_nxt   = '0;
    wb_mdata_nxt = '0;
    wb_m2reg_nxt = 1'b0;
    wb_wreg_nxt  = 1'b0;
    wb_rn_nxt    = '0;
    case (state)
      IDLE: begin
        mem_stall = memop;
        if (memop) begin
          dm_req_nxt   = 1'b1;
          dm_we_nxt    = mem_wmem;
          dm_addr_nxt  = mem_Alu_Result;
          dm_wdata_nxt = mem_rb;
        end else begin
          wb_alu_nxt  = mem_Alu_Result;
          wb_rn_nxt   = mem_rn;
          wb_wreg_nxt = mem_wreg;
        end
      end
      BUSY: begin
        if (dm_ready) begin
          dm_req_nxt   = 1'b0;
          wb_alu_nxt   = mem_Alu_Result;
          wb_rn_nxt    = mem_rn;
          wb_wreg_nxt  = mem_wreg;
          wb_m2reg_nxt = is_load;
          wb_mdata_nxt = is_load ? dm_rdata : 32'h0;
        end else if (wait_last) begin
          // Abort: retire the instruction without its register write.
          dm_req_nxt  = 1'b0;
          bus_err_nxt = 1'b1;
          wb_alu_nxt  = mem_Alu_Result;
          wb_rn_nxt   = mem_rn;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: mem_stall = 1'b0;
    endcase
  end

  // MEM/WB and bus register boundary
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dm_req        <= 1'b0;
      dm_we         <= 1'b0;
      dm_addr       <= '0;
      dm_wdata      <= '0;
      wb_Alu_Result <= '0;
      wb_mdata      <= '0;
      wb_m2reg      <= 1'b0;
      wb_wreg       <= 1'b0;
      wb_rn         <= '0;
      bus_err       <= 1'b0;
    end else begin
      dm_req        <= dm_req_nxt;
      dm_we         <= dm_we_nxt;
      dm_addr       <= dm_addr_nxt;
      dm_wdata      <= dm_wdata_nxt;
      wb_Alu_Result <= wb_alu_nxt;
      wb_mdata      <= wb_mdata_nxt;
      wb_m2reg      <= wb_m2reg_nxt;
      wb_wreg       <= wb_wreg_nxt;
      wb_rn         <= wb_rn_nxt;
      bus_err       <= bus_err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: per-cycle comparison against a behavioural model
// plus directed scenarios with literal expectations.
module tb_mem_stage_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] mem_Alu_Result, mem_rb, dm_rdata;
  logic        mem_wmem, mem_m2reg, mem_wreg, dm_ready;
  logic [4:0]  mem_rn;
  logic        mem_stall, dm_req, dm_we, wb_m2reg, wb_wreg, bus_err;
  logic [31:0] dm_addr, dm_wdata, wb_Alu_Result, wb_mdata;
  logic [4:0]  wb_rn;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int req_cnt = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT_CYC(T), .CNT_W(8)) dut (
    .clk(clk), .clrn(clrn),
    .mem_Alu_Result(mem_Alu_Result), .mem_rb(mem_rb),
    .mem_wmem(mem_wmem), .mem_m2reg(mem_m2reg), .mem_wreg(mem_wreg), .mem_rn(mem_rn),
    .mem_stall(mem_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .wb_Alu_Result(wb_Alu_Result), .wb_mdata(wb_mdata), .wb_m2reg(wb_m2reg),
    .wb_wreg(wb_wreg), .wb_rn(wb_rn), .bus_err(bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding access at a time, counted in wait cycles.
  bit          m_busy;
  int          m_waits;
  logic        m_req, m_we, m_m2reg, m_wreg, m_err;
  logic [31:0] m_addr, m_wdata, m_alu, m_mdata;
  logic [4:0]  m_rn;

  task automatic m_wb(input logic [31:0] alu, input logic [4:0] rn, input logic wr,
                      input logic m2r, input logic [31:0] md);
    m_alu = alu; m_rn = rn; m_wreg = wr; m_m2reg = m2r; m_mdata = md;
  endtask

  always @(posedge clk or negedge clrn) begin : model
    logic ld;
    if (!clrn) begin
      m_busy = 0; m_waits = 0; m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_err = 0;
      m_wb(32'h0, 5'h0, 1'b0, 1'b0, 32'h0);
    end else begin
      ld = mem_m2reg & ~mem_wmem;
      if (!m_busy) begin
        if (mem_wmem | mem_m2reg) begin
          m_busy = 1; m_waits = 0; m_req = 1; m_we = mem_wmem;
          m_addr = mem_Alu_Result; m_wdata = mem_rb;
          m_wb(32'h0, 5'h0, 1'b0, 1'b0, 32'h0);
        end else begin
          m_wb(mem_Alu_Result, mem_rn, mem_wreg, 1'b0, 32'h0);
        end
      end else if (dm_ready) begin
        m_busy = 0; m_req = 0;
        m_wb(mem_Alu_Result, mem_rn, mem_wreg, ld, ld ? dm_rdata : 32'h0);
      end else if (m_waits == T - 1) begin
        m_busy = 0; m_req = 0; m_err = 1;
        m_wb(mem_Alu_Result, mem_rn, 1'b0, 1'b0, 32'h0);
      end else begin
        m_waits++;
        m_wb(32'h0, 5'h0, 1'b0, 1'b0, 32'h0);
      end
    end
  end

  always @(negedge clk) begin : compare
    logic exp_stall;
    exp_stall = m_busy ? !(dm_ready || m_waits == T - 1) : (mem_wmem | mem_m2reg);
    chk("mem_stall", {31'h0, mem_stall}, {31'h0, exp_stall});
    chk("dm_req", {31'h0, dm_req}, {31'h0, m_req});
    chk("dm_we", {31'h0, dm_we}, {31'h0, m_we});
    chk("dm_addr", dm_addr, m_addr);
    chk("dm_wdata", dm_wdata, m_wdata);
    chk("wb_Alu_Result", wb_Alu_Result, m_alu);
    chk("wb_mdata", wb_mdata, m_mdata);
    chk("wb_m2reg", {31'h0, wb_m2reg}, {31'h0, m_m2reg});
    chk("wb_wreg", {31'h0, wb_wreg}, {31'h0, m_wreg});
    chk("wb_rn", {27'h0, wb_rn}, {27'h0, m_rn});
    chk("bus_err", {31'h0, bus_err}, {31'h0, m_err});
  end

  task automatic drive(input logic w, input logic m, input logic wr, input logic [4:0] rn,
                       input logic [31:0] alu, input logic [31:0] rb);
    mem_wmem = w; mem_m2reg = m; mem_wreg = wr; mem_rn = rn;
    mem_Alu_Result = alu; mem_rb = rb;
  endtask

  // One cycle: count stall/req in the middle, return 1 time unit after the edge.
  task automatic tick();
    @(negedge clk);
    if (mem_stall) stall_cnt++;
    if (dm_req) req_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clrn = 1'b0;
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
    dm_ready = 1'b0; dm_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset dm_req", {31'h0, dm_req}, 32'h0);
    chk("reset bus_err", {31'h0, bus_err}, 32'h0);
    chk("reset wb_wreg", {31'h0, wb_wreg}, 32'h0);
    clrn = 1'b1;
    tick();

    // ALU op
    stall_cnt = 0;
    drive(0, 0, 1, 5'd5, 32'h12, 32'h0);
    tick();
    chk("alu wb_wreg", {31'h0, wb_wreg}, 32'h1);
    chk("alu wb_rn", {27'h0, wb_rn}, 32'd5);
    chk("alu wb_Alu_Result", wb_Alu_Result, 32'h12);
    chk("alu stall cycles", stall_cnt, 0);
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
    tick();

    // Zero-wait load
    stall_cnt = 0;
    drive(0, 1, 1, 5'd3, 32'h40, 32'h0);
    tick();
    chk("load dm_req", {31'h0, dm_req}, 32'h1);
    chk("load dm_addr", dm_addr, 32'h40);
    chk("load dm_we", {31'h0, dm_we}, 32'h0);
    dm_ready = 1'b1; dm_rdata = 32'hDEADBEEF;
    tick();
    chk("load wb_mdata", wb_mdata, 32'hDEADBEEF);
    chk("load wb_m2reg", {31'h0, wb_m2reg}, 32'h1);
    chk("load wb_rn", {27'h0, wb_rn}, 32'd3);
    chk("load wb_wreg", {31'h0, wb_wreg}, 32'h1);
    chk("load stall cycles", stall_cnt, 1);
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
    dm_ready = 1'b0;
    tick();

    // Store with 3 wait cycles
    stall_cnt = 0; req_cnt = 0;
    drive(1, 0, 0, 5'd9, 32'h80, 32'h55);
    tick();
    chk("store dm_we", {31'h0, dm_we}, 32'h1);
    chk("store dm_wdata", dm_wdata, 32'h55);
    repeat (3) tick();
    dm_ready = 1'b1;
    tick();
    chk("store req cycles", req_cnt, 4);
    chk("store stall cycles", stall_cnt, 4);
    chk("store wb_wreg", {31'h0, wb_wreg}, 32'h0);
    chk("store wb_Alu_Result", wb_Alu_Result, 32'h80);
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
    dm_ready = 1'b0;
    tick();

    // Timeout on a load
    stall_cnt = 0; req_cnt = 0;
    drive(0, 1, 1, 5'd7, 32'h100, 32'h0);
    tick();
    repeat (T) tick();
    chk("timeout req cycles", req_cnt, T);
    chk("timeout stall cycles", stall_cnt, T);
    chk("timeout bus_err", {31'h0, bus_err}, 32'h1);
    chk("timeout wb_wreg", {31'h0, wb_wreg}, 32'h0);
    chk("timeout wb_rn", {27'h0, wb_rn}, 32'd7);
    chk("timeout dm_req", {31'h0, dm_req}, 32'h0);
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
    dm_ready = 1'b1; dm_rdata = 32'hAAAA5555;
    tick();
    chk("late ready bus_err", {31'h0, bus_err}, 32'h1);
    chk("late ready dm_req", {31'h0, dm_req}, 32'h0);
    chk("late ready wb_mdata", wb_mdata, 32'h0);
    dm_ready = 1'b0;
    tick();

    // Back-to-back load then store
    stall_cnt = 0;
    drive(0, 1, 1, 5'd2, 32'h10, 32'h0);
    tick();
    dm_ready = 1'b1; dm_rdata = 32'h1234;
    tick();
    chk("b2b load wb_mdata", wb_mdata, 32'h1234);
    chk("b2b idle gap dm_req", {31'h0, dm_req}, 32'h0);
    drive(1, 0, 0, 5'd0, 32'h20, 32'h99);
    dm_ready = 1'b0;
    tick();
    chk("b2b store dm_req", {31'h0, dm_req}, 32'h1);
    chk("b2b store dm_addr", dm_addr, 32'h20);
    chk("b2b store dm_wdata", dm_wdata, 32'h99);
    dm_ready = 1'b1;
    tick();
    chk("b2b stall cycles", stall_cnt, 2);
    chk("b2b store dm_req off", {31'h0, dm_req}, 32'h0);
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
    dm_ready = 1'b0;
    tick();

    // Reset in the middle of a pending load
    drive(0, 1, 1, 5'd4, 32'h200, 32'h0);
    tick();
    chk("pre-reset dm_req", {31'h0, dm_req}, 32'h1);
    #2 clrn = 1'b0;
    #1;
    chk("async reset dm_req", {31'h0, dm_req}, 32'h0);
    chk("async reset bus_err", {31'h0, bus_err}, 32'h0);
    chk("async reset wb_wreg", {31'h0, wb_wreg}, 32'h0);
    chk("async reset wb_Alu_Result", wb_Alu_Result, 32'h0);
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
    tick();
    tick();
    clrn = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
